stream_demux_1ton: RTL

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshake on every side. Routes each accepted input word to the output channel given by its select field. Each channel has its own one-entry output register, so one stalled channel never blocks traffic to the others. Successor to the combinational 1:2 demux; used wherever a single producer feeds several independently-throttled consumers.

---
 rtl/stream_demux_1ton.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/stream_demux_1ton.sv
// ---------------------------------------------------------------------------
// stream_demux_1ton
//
// Registered 1-to-N stream demultiplexer with valid/ready handshakes on the
// input and on every output channel. Each accepted input word is routed to
// the channel named by its select field. Every channel owns a one-entry
// output register, so a stalled consumer only back-pressures words aimed at
// its own channel. Words carrying a select value >= NUM_CH are accepted,
// dropped, and counted in a saturating 8-bit counter.
//
// Optional feature (macro STREAM_DEMUX_RR_MODE_EN):
//   Adds input rr_mode. While rr_mode=1 the destination comes from an
//   internal round-robin pointer instead of in_sel. The pointer advances on
//   every accept, wraps at NUM_CH-1, and never skips a busy channel (the
//   input stalls instead).
//
// Parameters:
//   DATA_W  width of a data word
//   NUM_CH  number of output channels (2..16)
//   SEL_W   select width, derived from NUM_CH (do not override)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   rr_mode      (macro only) route by round-robin pointer instead of in_sel
//   in_valid     input word present
//   in_ready     input word accepted this cycle (0 while in reset)
//   in_data      input word
//   in_sel       destination channel for in_data
//   out_valid    per-channel word present
//   out_ready    per-channel consumer accepts
//   out_data     channel k at bits [k*DATA_W +: DATA_W]
//   bad_sel_cnt  number of words dropped for an out-of-range select (sat 255)
// ---------------------------------------------------------------------------
module stream_demux_1ton #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef STREAM_DEMUX_RR_MODE_EN
    input  logic                     rr_mode,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [7:0]               bad_sel_cnt
);

    // One extra bit so NUM_CH itself is representable for the range compare.
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]         dest;
    logic                     dest_in_range;
    logic                     slot_ready;
    logic                     accept;

    logic [NUM_CH-1:0]        out_valid_d,   out_valid_q;
    logic [NUM_CH*DATA_W-1:0] out_data_d,    out_data_q;
    logic [7:0]               bad_sel_cnt_d, bad_sel_cnt_q;

`ifdef STREAM_DEMUX_RR_MODE_EN
    logic [SEL_W-1:0]         rr_ptr_d, rr_ptr_q;
`endif

    // -----------------------------------------------------------------------
    // Destination decode and input handshake
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        slot_ready = 1'b0;

`ifdef STREAM_DEMUX_RR_MODE_EN
        dest = rr_mode ? rr_ptr_q : in_sel;
`else
        dest = in_sel;
`endif
        dest_in_range = ({1'b0, dest} < CH_LIMIT);

        // Compare against each channel rather than indexing with dest, so an
        // out-of-range select never reads past the end of the vectors.
        for (int k = 0; k < NUM_CH; k++) begin
            if (dest == SEL_W'(k)) begin
                slot_ready = ~out_valid_q[k] | out_ready[k];
            end
        end

        // Out-of-range words are always taken so they can be dropped; a full
        // slot still accepts when it drains in the same cycle.
        in_ready = rst_n & (dest_in_range ? slot_ready : 1'b1);
        accept   = in_valid & in_ready;
    end

    // -----------------------------------------------------------------------
    // Next-state logic: channel slots, drop counter, round-robin pointer
    // -----------------------------------------------------------------------
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        bad_sel_cnt_d = bad_sel_cnt_q;

        // Load has priority over drain so a slot can drain and refill on the
        // same edge, sustaining one word per cycle per channel.
        for (int k = 0; k < NUM_CH; k++) begin
            if (accept && (dest == SEL_W'(k))) begin
                out_data_d[k*DATA_W +: DATA_W] = in_data;
                out_valid_d[k]                 = 1'b1;
            end else if (out_valid_q[k] && out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end

        if (accept && !dest_in_range && (bad_sel_cnt_q != 8'hFF)) begin
            bad_sel_cnt_d = bad_sel_cnt_q + 8'd1;
        end
    end

`ifdef STREAM_DEMUX_RR_MODE_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rr_mode && accept) begin
            rr_ptr_d = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data registers are reset along with the valids because
        // out_data is defined as 0 in reset; they are flops, not a RAM, so the
        // reset costs nothing structural.
        if (!rst_n) begin
            out_valid_q   <= '0;
            out_data_q    <= '0;
            bad_sel_cnt_q <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples the pre-edge values computed above.
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            bad_sel_cnt_q <= bad_sel_cnt_d;
        end
    end

`ifdef STREAM_DEMUX_RR_MODE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Keep the constant referenced in the default build.
    logic unused_last_ch;
    assign unused_last_ch = ^LAST_CH;
`endif

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign bad_sel_cnt = bad_sel_cnt_q;

endmodule
